// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style 8-bit LCD bus: single reads and a
// busy-flag poll loop with timeout. All outputs are registered.
module lcd_bus_reader #(
  parameter int T_AS     = 3,
  parameter int T_EN     = 13,
  parameter int T_H      = 2,
  parameter int T_GAP    = 8,
  parameter int POLL_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       poll_req,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic       poll_done,
  output logic       poll_timeout,
  output logic [7:0] rd_data,
  output logic       bus_own,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  input  logic [7:0] LCD_DATA_in
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, GAP} state_t;

  state_t          state_reg;
  logic [15:0]     cnt_reg;
  logic [PW-1:0]   poll_cnt_reg;
  logic            poll_mode_reg;
  logic            poll_more_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      poll_cnt_reg  <= '0;
      poll_mode_reg <= 1'b0;
      poll_more_reg <= 1'b0;
      rd_ready      <= 1'b1;
      rd_valid      <= 1'b0;
      poll_done     <= 1'b0;
      poll_timeout  <= 1'b0;
      rd_data       <= 8'h00;
      bus_own       <= 1'b0;
      LCD_RS        <= 1'b0;
      LCD_RW        <= 1'b0;
      LCD_EN        <= 1'b0;
    end else begin
      rd_valid     <= 1'b0;
      poll_done    <= 1'b0;
      poll_timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          // poll_req wins a tie; the losing request is simply dropped
          if (poll_req || rd_req) begin
            poll_mode_reg <= poll_req;
            LCD_RS        <= poll_req ? 1'b0 : rd_rs;
            poll_cnt_reg  <= '0;
            cnt_reg       <= '0;
            state_reg     <= SETUP;
            bus_own       <= 1'b1;
            LCD_RW        <= 1'b1;
            rd_ready      <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_reg == 16'(T_AS - 1)) begin
            cnt_reg   <= '0;
            LCD_EN    <= 1'b1;
            state_reg <= EN_HIGH;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        EN_HIGH: begin
          if (cnt_reg == 16'(T_EN - 1)) begin
            cnt_reg   <= '0;
            rd_data   <= LCD_DATA_in;
            LCD_EN    <= 1'b0;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        HOLD: begin
          if (cnt_reg == 16'(T_H - 1)) begin
            cnt_reg   <= '0;
            LCD_RW    <= 1'b0;
            state_reg <= GAP;
            // rd_data already holds the byte sampled as EN fell
            if (!poll_mode_reg) begin
              rd_valid      <= 1'b1;
              poll_more_reg <= 1'b0;
            end else if (!rd_data[7]) begin
              poll_done     <= 1'b1;
              poll_more_reg <= 1'b0;
            end else if (poll_cnt_reg + PW'(1) == PW'(POLL_MAX)) begin
              poll_timeout  <= 1'b1;
              poll_more_reg <= 1'b0;
            end else begin
              poll_cnt_reg  <= poll_cnt_reg + PW'(1);
              poll_more_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        GAP: begin
          if (cnt_reg == 16'(T_GAP - 1)) begin
            cnt_reg <= '0;
            if (poll_more_reg) begin
              LCD_RW    <= 1'b1;
              state_reg <= SETUP;
            end else begin
              bus_own   <= 1'b0;
              rd_ready  <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style 8-bit LCD parallel bus; the counterpart of the existing write-only LCD command/data driver.
- Runs single read cycles (RW=1) to fetch DDRAM/CGRAM data (RS=1) or the busy flag plus address counter (RS=0).
- Also runs an autonomous busy-flag poll loop with timeout, so the writer can wait for LCD-ready instead of using fixed delays.
- Sits beside the writer. The top level muxes RS/RW/EN and tristates LCD_DATA whenever bus_own=1.

Parameters:
- T_AS, 3, RS/RW setup cycles before EN rises (≥1).
- T_EN, 13, EN high cycles; data is sampled on the last one (≥1).
- T_H, 2, cycles after EN falls with RW/RS still held (≥1).
- T_GAP, 8, recovery cycles before the next access (≥1).
- POLL_MAX, 1024, maximum busy-flag reads per poll before timeout (≥1).

Ports:
- clk  in  1  system clock (defaults sized for 50 MHz).
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  single-read request; accepted when rd_ready=1.
- rd_rs  in  1  RS value for the single read; captured at accept.
- poll_req  in  1  start busy-flag poll; accepted when rd_ready=1.
- rd_ready  out  1  high only in IDLE.
- rd_valid  out  1  one-cycle pulse; rd_data holds the single-read result.
- poll_done  out  1  one-cycle pulse; BF read as 0, rd_data = {1'b0, AC}.
- poll_timeout  out  1  one-cycle pulse; POLL_MAX reads all returned BF=1.
- rd_data  out  8  last sampled byte; held until the next sample.
- bus_own  out  1  high from accept until GAP ends.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  1 during SETUP/EN_HIGH/HOLD, otherwise 0.
- LCD_EN  out  1  enable strobe, registered.
- LCD_DATA_in  in  8  LCD data bus input.

Behaviour:
- Reset (synchronous, takes effect at the next clk edge, overrides everything, including mid-cycle):
  - state=IDLE, all counters 0.
  - LCD_EN=0, LCD_RW=0, LCD_RS=0, bus_own=0.
  - rd_valid/poll_done/poll_timeout=0, rd_data=8'h00, rd_ready=1 in the cycle after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, EN_HIGH, HOLD, GAP.
- IDLE:
  - poll_req has priority over rd_req when both are high; the loser is ignored, not queued.
  - On accept: latch mode (single/poll). RS = rd_rs for single, 0 for poll. Clear poll_cnt. Go to SETUP. bus_own=1, LCD_RW=1.
  - Requests while rd_ready=0 are ignored.
- SETUP: T_AS cycles with RW=1, EN=0, then EN_HIGH.
- EN_HIGH: T_EN cycles with EN=1. On the clock edge ending the last EN_HIGH cycle, rd_data<=LCD_DATA_in and EN<=0. Then HOLD.
- HOLD: T_H cycles with RW=1, RS held. On exit, LCD_RW<=0 and go to GAP.
- GAP: T_GAP cycles with bus_own=1. Status pulses are high for the first GAP cycle only:
  - single mode: rd_valid.
  - poll mode, rd_data[7]=0: poll_done.
  - poll mode, rd_data[7]=1 and poll_cnt+1==POLL_MAX: poll_timeout.
  - Otherwise no pulse; increment poll_cnt.
  - On GAP end: if poll mode is still running, go to SETUP (RW=1 again); otherwise go to IDLE with bus_own=0 and rd_ready=1.
- Single-read timing:
  - With the accept edge as edge 0, EN rises at edge T_AS and falls at edge T_AS+T_EN.
  - rd_valid is high between edges T_AS+T_EN+T_H and +1.
  - rd_ready returns at edge T_AS+T_EN+T_H+T_GAP (26 with defaults).
- poll_cnt is sized $clog2(POLL_MAX+1) bits and never wraps.
- Poll length: at most POLL_MAX complete read cycles, each T_AS+T_EN+T_H+T_GAP long.
- The gap between rd_ready falling and LCD_EN rising is always ≥T_AS cycles. RW never changes while EN=1.

Test Plan:
- Reset, then single read rd_rs=1 with LCD_DATA_in=8'hA5 stable → EN high for exactly 13 cycles; rd_valid 1 cycle, 18 cycles after accept, rd_data=8'hA5, LCD_RS=1; rd_ready back after 26 cycles.
- LCD_DATA_in changes 8'h11→8'h22 one cycle before EN falls → rd_data=8'h22. Changing it after the sample edge → rd_data unaffected.
- Poll: LCD model returns 8'h80|AC for 3 reads, then 8'h2C → exactly 4 EN pulses, all with RS=0; poll_done once, rd_data=8'h2C; no rd_valid.
- Poll with POLL_MAX=4 and BF stuck at 1 → 4 EN pulses; poll_timeout pulses once; back to IDLE; bus_own=0.
- rd_req and poll_req high on the same cycle → poll executes with RS=0. rd_req pulses while busy → no extra cycles and no extra rd_valid.
- Assert rst during EN_HIGH → at the next edge EN=0, RW=0, bus_own=0, rd_ready=1 the cycle after; no status pulse; a new rd_req then completes normally.
